// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg
// Shared types and constants for the 16-bit AES-style round sequencer and the
// external transform units: transform opcodes, sequencer state encoding and
// the 4x4 cell layout of the cipher state.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  // Cipher state geometry: 4 rows x 4 columns of cells
  localparam int STATE_W  = 16;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CELL_W   = STATE_W / (NUM_ROWS * NUM_COLS);

  // Transform selects on the shared datapath port
  localparam logic [1:0] OP_SUB   = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_MIX   = 2'b10;

  // Round sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARK  = 3'd1,
    ST_SUB  = 3'd2,
    ST_SHR  = 3'd3,
    ST_MIX  = 3'd4,
    ST_DONE = 3'd5
  } rnd_state_e;

  // LSB position of cell (row, col); cells are packed column-major
  function automatic int cell_lsb(input int row, input int col);
    return (col * NUM_ROWS + row) * CELL_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_fsm.sv
// ============================================================================
// aes_round_fsm
// Round-schedule state machine and round counter. Walks IDLE -> ARK ->
// (SUB -> SHR -> MIX -> ARK)* -> DONE, skipping MIX in the final round, and
// produces registered handshake/status controls for the top level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_round_fsm
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       dp_ack_i,
  input  logic       key_valid_i,
  input  logic       abort_i,
  output rnd_state_e state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       dp_req_o,
  output logic [1:0] dp_op_o,
  output logic       key_req_o
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  rnd_state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       busy_q, done_q, dp_req_q, key_req_q;
  logic [1:0] dp_op_q;

  // Next-state and round-counter logic; abort forces a return to IDLE
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_ARK;
        round_d = 4'd0;
      end
      ST_ARK: if (key_valid_i) begin
        if (round_q == LAST_RND) begin
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = ST_SUB;
        end
      end
      ST_SUB:  if (dp_ack_i) state_d = ST_SHR;
      ST_SHR:  if (dp_ack_i) state_d = (round_q < LAST_RND) ? ST_MIX : ST_ARK;
      ST_MIX:  if (dp_ack_i) state_d = ST_ARK;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  // State register with outputs registered from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      round_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dp_req_q  <= 1'b0;
      dp_op_q   <= OP_SUB;
      key_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      busy_q    <= state_d inside {ST_ARK, ST_SUB, ST_SHR, ST_MIX};
      done_q    <= (state_d == ST_DONE);
      dp_req_q  <= state_d inside {ST_SUB, ST_SHR, ST_MIX};
      key_req_q <= (state_d == ST_ARK);
      case (state_d)
        ST_SHR:  dp_op_q <= OP_SHIFT;
        ST_MIX:  dp_op_q <= OP_MIX;
        default: dp_op_q <= OP_SUB;
      endcase
    end
  end

  assign state_o   = state_q;
  assign round_o   = round_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign dp_req_o  = dp_req_q;
  assign dp_op_o   = dp_op_q;
  assign key_req_o = key_req_q;

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// aes_round_ctrl
// Round sequencer top: holds the cipher state register, performs
// AddRoundKey, and drives the shared transform port and key port through
// aes_round_fsm. Optional handshake watchdog enabled by defining
// AES_ROUND_CTRL_TIMEOUT_EN (otherwise err is tied low and waits are
// unbounded).
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int WIDTH      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             dp_req,
  output logic [1:0]       dp_op,
  output logic [WIDTH-1:0] dp_data,
  input  logic             dp_ack,
  input  logic [WIDTH-1:0] dp_result,
  output logic             key_req,
  output logic [3:0]       key_round,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] round_key,
  output logic             err
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // Reject parameter sets the 4-bit round counter or cell layout cannot hold
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15 || WIDTH != STATE_W ||
      NUM_ROWS * NUM_COLS * CELL_W != STATE_W ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("aes_round_ctrl: illegal parameter set");
  end

  rnd_state_e       fsm_state;
  logic [WIDTH-1:0] cstate_q;
  logic [WIDTH-1:0] data_out_q;
  logic             load, ark_fire, dp_fire, last_ark, abort;

  assign load     = (fsm_state == ST_IDLE) && start;
  assign ark_fire = (fsm_state == ST_ARK) && key_valid;
  assign dp_fire  = (fsm_state inside {ST_SUB, ST_SHR, ST_MIX}) && dp_ack;
  assign last_ark = ark_fire && (key_round == LAST_RND);

  aes_round_fsm #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .dp_ack_i   (dp_ack),
    .key_valid_i(key_valid),
    .abort_i    (abort),
    .state_o    (fsm_state),
    .round_o    (key_round),
    .busy_o     (busy),
    .done_o     (done),
    .dp_req_o   (dp_req),
    .dp_op_o    (dp_op),
    .key_req_o  (key_req)
  );

  // Cipher state: load plaintext, XOR round key, or take transform result;
  // the final AddRoundKey result is captured straight into data_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cstate_q   <= '0;
      data_out_q <= '0;
    end else begin
      if (load)          cstate_q <= data_in;
      else if (ark_fire) cstate_q <= cstate_q ^ round_key;
      else if (dp_fire)  cstate_q <= dp_result;
      if (last_ark) data_out_q <= cstate_q ^ round_key;
    end
  end

  assign dp_data  = cstate_q;
  assign data_out = data_out_q;

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_q;
  logic       err_q;
  logic       in_hs;

  assign in_hs = fsm_state inside {ST_ARK, ST_SUB, ST_SHR, ST_MIX};
  // Abort on the TIMEOUT-th consecutive unanswered cycle of one handshake
  assign abort = in_hs && !(ark_fire || dp_fire) && (wait_q == WAIT_LAST);

  // Wait counter clears whenever a new handshake step begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (load || ark_fire || dp_fire) wait_q <= 8'd0;
      else if (in_hs)                  wait_q <= wait_q + 8'd1;
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the 16-bit (4×4-cell) AES-style cipher datapath. It owns the cipher state register and walks it through the round schedule: initial AddRoundKey, then SubBytes → ShiftRows → MixColumns → AddRoundKey per round, with the final round skipping MixColumns. The transform units (SubBytes, ShiftRows, MixColumns) are external and shared through a single req/ack port; round keys arrive over a separate key handshake. AddRoundKey is performed internally.

## Interface
- NUM_ROUNDS, 10, number of rounds; legal range 1–15.
- WIDTH, 16, state width in bits; fixed at 16 for the 4×4 cell layout.
- TIMEOUT, 255, maximum wait cycles on any handshake; used only with the timeout feature (see Configuration).
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin encryption of data_in; sampled only in IDLE.
- data_in  in  16  plaintext, captured on accepted start.
- busy  out  1  high from start acceptance until the cycle done or err pulses.
- done  out  1  one-cycle pulse when data_out is valid.
- data_out  out  16  ciphertext; holds its value until the next accepted start.
- dp_req  out  1  transform request.
- dp_op  out  2  transform select: 00 SubBytes, 01 ShiftRows, 10 MixColumns.
- dp_data  out  16  current state presented to the transform.
- dp_ack  in  1  transform complete; dp_result is valid in the same cycle.
- dp_result  in  16  transformed state.
- key_req  out  1  round-key request.
- key_round  out  4  index of the requested round key, 0..NUM_ROUNDS.
- key_valid  in  1  round_key is valid in this cycle.
- round_key  in  16  round key.
- err  out  1  one-cycle timeout pulse (timeout feature only; otherwise tied to 0).

## Operation
- FSM states: IDLE, ARK, SUB, SHR, MIX, DONE.
- IDLE + start:
  - state ← data_in
  - round ← 0
  - go to ARK.
- ARK:
  - key_req=1, key_round=round.
  - On key_valid: state ← state ^ round_key.
  - If round==NUM_ROUNDS → DONE; else round ← round+1 and go to SUB.
- SUB / SHR / MIX:
  - dp_req=1, dp_op per state, dp_data=state.
  - On dp_ack: state ← dp_result.
  - Transitions: SUB→SHR; SHR→MIX if round<NUM_ROUNDS, else SHR→ARK; MIX→ARK.
- DONE:
  - data_out ← state, done=1, busy drops, go to IDLE.
- Request hold: dp_req, dp_op and dp_data stay stable until ack. Same rule for key_req and key_round.
- Ignored inputs:
  - dp_ack outside SUB/SHR/MIX.
  - key_valid outside ARK.
  - start while busy.
- Round counter is 4 bits and never wraps, given the legal NUM_ROUNDS range.

## Timing
- Reset values: busy=0, done=0, err=0, dp_req=0, dp_op=00, dp_data=0, key_req=0, key_round=0, data_out=0; FSM in IDLE.
- An ack arriving in the first cycle of a request completes the step in that cycle. Each step costs 1 + (wait cycles).
- With acks tied high, latency from the start-accept edge to done is 4·NUM_ROUNDS cycles, i.e. 40 for NUM_ROUNDS=10.
- start asserted in the DONE cycle is ignored. A new start is accepted one cycle after done.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). No done is produced.

## Configuration
- AES_ROUND_CTRL_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entering any handshake state and increments each cycle without ack/key_valid.
  - When the counter reaches TIMEOUT: pulse err for 1 cycle, drop busy and all requests, return to IDLE.
  - data_out is unchanged and done is not pulsed.
- Undefined: no counter; waits are unbounded; err is tied to 0.

## Structure
- Shared package aes_pkg:
  - dp_op encodings (OP_SUB, OP_SHIFT, OP_MIX)
  - FSM state enum
  - STATE_W=16
  - cell-index helper constants shared with the transform units.
- One sub-module, aes_round_fsm:
  - FSM and round counter, producing the state/round controls.
  - The top level holds the state register, the XOR, and the optional timeout counter.

## Test plan
- Zero-wait run, NUM_ROUNDS=10, with dp_result=dp_data^16'h0001 stub and round_key=16'h0000:
  - done exactly 40 cycles after start.
  - data_out = data_in ^ 16'h0001·(parity of 29 transforms) = data_in^1.
  - Observed dp_op sequence: 00,01,10 ×9, then 00,01.
- Key handshake with round_key=key_round-replicated, data_in=16'hB20F:
  - key_round steps 0..10.
  - data_out matches the reference model.
  - Injecting 3 wait cycles on key_valid adds exactly 3 cycles of latency.
- Hold check: dp_ack withheld for 5 cycles in SHR → dp_req/dp_op/dp_data remain constant; state is unchanged until ack.
- Start while busy (pulse at cycle 10) → ignored; a single done; data_out is unaffected.
- rst_n low at cycle 17 mid-MIX → outputs go to their reset values at once, no done; a new start after release completes normally in 40 cycles.
- With AES_ROUND_CTRL_TIMEOUT_EN and TIMEOUT=255, dp_ack held low → err pulses at wait-cycle 255, busy=0, FSM in IDLE, data_out unchanged.
